// File: rtl/sum_accumulator.sv
// Batch accumulator for a 7-bit adder result {cout,s}: sums N_SAMPLES results, then holds them until downstream accepts.
// Define SUM_ACCUMULATOR_SATURATE_EN to clamp the sum at its maximum value; by default the sum wraps and sets a sticky overflow flag.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_ACCUM | accepting samples, building the batch sum
// ST_HOLD  | batch complete, result presented until out_ready
module sum_accumulator #(
   parameter int N_SAMPLES = 4,
   parameter int ACC_W     = 12
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [5:0]       s,
   input  logic             cout,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] acc,
   output logic             ovf,
   output logic [7:0]       cnt
);

   typedef enum logic {
      ST_ACCUM = 1'b0,
      ST_HOLD  = 1'b1
   } state_t;

   localparam int            LP_SUM_W = ACC_W + 1;
   localparam logic [7:0]    LP_LAST  = 8'(N_SAMPLES - 1);

   state_t             r_state;
   state_t             w_state_nxt;
   logic [ACC_W-1:0]   r_acc;
   logic               r_ovf;
   logic [7:0]         r_cnt;
   logic               w_accept;
   logic               w_drain;
   logic [ACC_W:0]     w_sum;
   logic [ACC_W-1:0]   w_acc_nxt;
   logic               w_ovf_nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_ACCUM;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      case (r_state)
         ST_ACCUM: begin
            in_ready = ~clr;
            if (in_valid && !clr && (r_cnt == LP_LAST)) begin
               w_state_nxt = ST_HOLD;
            end
         end
         ST_HOLD: begin
            out_valid = 1'b1;
            if (out_ready) begin
               w_state_nxt = ST_ACCUM;
            end
         end
         default: w_state_nxt = ST_ACCUM;
      endcase
      // clr discards the batch regardless of state or handshake
      if (clr) begin
         w_state_nxt = ST_ACCUM;
      end
   end

   assign w_accept = in_valid & in_ready;
   assign w_drain  = (r_state == ST_HOLD) & out_ready;
   assign w_sum    = {1'b0, r_acc} + LP_SUM_W'({cout, s});

   always_comb begin
      w_acc_nxt = w_sum[ACC_W-1:0];
      w_ovf_nxt = r_ovf | w_sum[ACC_W];
`ifdef SUM_ACCUMULATOR_SATURATE_EN
      if (w_sum[ACC_W]) begin
         w_acc_nxt = '1;
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc <= '0;
         r_ovf <= 1'b0;
         r_cnt <= 8'd0;
      end else if (clr || w_drain) begin
         r_acc <= '0;
         r_ovf <= 1'b0;
         r_cnt <= 8'd0;
      end else if (w_accept) begin
         r_acc <= w_acc_nxt;
         r_ovf <= w_ovf_nxt;
         r_cnt <= r_cnt + 8'd1;
      end
   end

   assign acc = r_acc;
   assign ovf = r_ovf;
   assign cnt = r_cnt;

endmodule

// File: tb/tb_sum_accumulator.sv
// Bench for sum_accumulator: directed vector table, hand-written corner sequences and a randomized run
// against a true-sum reference model over three parameter sets (4/12, 3/8, 1/7).
module tb_sum_accumulator;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       clr = 1'b0;
   logic       in_valid = 1'b0;
   logic [5:0] s = 6'd0;
   logic       cout = 1'b0;
   logic       out_ready = 1'b0;

   logic        a_rdy, a_ov, a_ovf, b_rdy, b_ov, b_ovf, c_rdy, c_ov, c_ovf;
   logic [11:0] a_acc;
   logic [7:0]  b_acc;
   logic [6:0]  c_acc;
   logic [7:0]  a_cnt, b_cnt, c_cnt;

   always #5 clk = ~clk;

   sum_accumulator #(.N_SAMPLES(4), .ACC_W(12)) dut_a (
      .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(a_rdy),
      .s(s), .cout(cout), .out_valid(a_ov), .out_ready(out_ready),
      .acc(a_acc), .ovf(a_ovf), .cnt(a_cnt));

   sum_accumulator #(.N_SAMPLES(3), .ACC_W(8)) dut_b (
      .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(b_rdy),
      .s(s), .cout(cout), .out_valid(b_ov), .out_ready(out_ready),
      .acc(b_acc), .ovf(b_ovf), .cnt(b_cnt));

   sum_accumulator #(.N_SAMPLES(1), .ACC_W(7)) dut_c (
      .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(c_rdy),
      .s(s), .cout(cout), .out_valid(c_ov), .out_ready(out_ready),
      .acc(c_acc), .ovf(c_ovf), .cnt(c_cnt));

   logic [31:0] o_acc [3];
   logic [7:0]  o_cnt [3];
   logic        o_rdy [3];
   logic        o_ov  [3];
   logic        o_ovf [3];

   assign o_acc[0] = 32'(a_acc);
   assign o_acc[1] = 32'(b_acc);
   assign o_acc[2] = 32'(c_acc);
   assign o_cnt[0] = a_cnt;
   assign o_cnt[1] = b_cnt;
   assign o_cnt[2] = c_cnt;
   assign o_rdy[0] = a_rdy;
   assign o_rdy[1] = b_rdy;
   assign o_rdy[2] = c_rdy;
   assign o_ov[0]  = a_ov;
   assign o_ov[1]  = b_ov;
   assign o_ov[2]  = c_ov;
   assign o_ovf[0] = a_ovf;
   assign o_ovf[1] = b_ovf;
   assign o_ovf[2] = c_ovf;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      bit c;
      bit iv;
      int v;
      bit ordy;
      bit rdy;
      bit ov;
      int acc;
      int cnt;
      bit ovf;
   } vec_t;

   vec_t tbl[$];

   // reference model: true (unbounded) batch sum per instance
   int  n_p [3] = '{4, 3, 1};
   int  w_p [3] = '{12, 8, 7};
   int  m_sum [3];
   int  m_cnt [3];
   bit  m_hold [3];

   function automatic vec_t mk(bit c, bit iv, int v, bit ordy, bit rdy, bit ov, int a, int n, bit f);
      vec_t t;
      t.c = c; t.iv = iv; t.v = v; t.ordy = ordy;
      t.rdy = rdy; t.ov = ov; t.acc = a; t.cnt = n; t.ovf = f;
      return t;
   endfunction

   task automatic chk(input string nm, input int k, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s[dut%0d] t=%0t got=%0d exp=%0d", nm, k, $time, act, exp);
      end
   endtask

   task automatic set_in(input bit c, input bit iv, input int v, input bit ordy);
      logic [6:0] op;
      op        = 7'(v);
      clr       = c;
      in_valid  = iv;
      cout      = op[6];
      s         = op[5:0];
      out_ready = ordy;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      set_in(0, 0, 0, 0);
      rst_n = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   function automatic longint exp_acc(int k);
      longint mx;
      mx = (longint'(1) << w_p[k]) - 1;
`ifdef SUM_ACCUMULATOR_SATURATE_EN
      return (m_sum[k] > mx) ? mx : longint'(m_sum[k]);
`else
      return longint'(m_sum[k]) & mx;
`endif
   endfunction

   task automatic model_check(input int k, input bit c);
      longint mx;
      mx = (longint'(1) << w_p[k]) - 1;
      chk("in_ready", k, o_rdy[k], (!m_hold[k] && !c) ? 1 : 0);
      chk("out_valid", k, o_ov[k], m_hold[k] ? 1 : 0);
      chk("acc", k, o_acc[k], exp_acc(k));
      chk("cnt", k, o_cnt[k], m_cnt[k]);
      chk("ovf", k, o_ovf[k], (m_sum[k] > mx) ? 1 : 0);
   endtask

   task automatic model_step(input int k, input bit c, input bit iv, input int v, input bit ordy);
      if (c) begin
         m_sum[k] = 0; m_cnt[k] = 0; m_hold[k] = 0;
      end else if (m_hold[k]) begin
         if (ordy) begin
            m_sum[k] = 0; m_cnt[k] = 0; m_hold[k] = 0;
         end
      end else if (iv) begin
         m_sum[k] += v;
         m_cnt[k] += 1;
         if (m_cnt[k] == n_p[k]) m_hold[k] = 1;
      end
   endtask

   initial begin
      // basic batch and backpressure
      tbl.push_back(mk(0,1,127,0, 1,0,  0,0,0));
      tbl.push_back(mk(0,1,  1,0, 1,0,127,1,0));
      tbl.push_back(mk(0,1, 64,0, 1,0,128,2,0));
      tbl.push_back(mk(0,1, 10,0, 1,0,192,3,0));
      tbl.push_back(mk(0,0,  0,0, 0,1,202,4,0));
      for (int i = 0; i < 4; i++) tbl.push_back(mk(0,1,5,0, 0,1,202,4,0));
      tbl.push_back(mk(0,1,  5,1, 0,1,202,4,0));
      tbl.push_back(mk(0,0,  0,0, 1,0,  0,0,0));
      // clr mid-batch
      tbl.push_back(mk(0,1,  5,0, 1,0,  0,0,0));
      tbl.push_back(mk(0,1,  7,0, 1,0,  5,1,0));
      tbl.push_back(mk(1,1,  9,0, 0,0, 12,2,0));
      tbl.push_back(mk(0,1,  3,0, 1,0,  0,0,0));
      tbl.push_back(mk(0,1,  3,0, 1,0,  3,1,0));
      tbl.push_back(mk(0,1,  3,0, 1,0,  6,2,0));
      tbl.push_back(mk(0,1,  3,0, 1,0,  9,3,0));
      tbl.push_back(mk(0,0,  0,1, 0,1, 12,4,0));
      // gapped input
      tbl.push_back(mk(0,1,100,0, 1,0,  0,0,0));
      tbl.push_back(mk(0,0,100,0, 1,0,100,1,0));
      tbl.push_back(mk(0,1,100,0, 1,0,100,1,0));
      tbl.push_back(mk(0,0,100,0, 1,0,200,2,0));
      tbl.push_back(mk(0,1,100,0, 1,0,200,2,0));
      tbl.push_back(mk(0,0,100,0, 1,0,300,3,0));
      tbl.push_back(mk(0,1,100,0, 1,0,300,3,0));
      tbl.push_back(mk(0,0,  0,0, 0,1,400,4,0));
      tbl.push_back(mk(0,0,  0,1, 0,1,400,4,0));
      tbl.push_back(mk(0,0,  0,0, 1,0,  0,0,0));

      do_reset();
      #3;
      chk("rst_in_ready", 0, a_rdy, 1);
      chk("rst_out_valid", 0, a_ov, 0);
      chk("rst_acc", 0, a_acc, 0);
      chk("rst_cnt", 0, a_cnt, 0);
      chk("rst_ovf", 0, a_ovf, 0);
      step();

      foreach (tbl[i]) begin
         set_in(tbl[i].c, tbl[i].iv, tbl[i].v, tbl[i].ordy);
         #3;
         chk($sformatf("tbl%0d_in_ready", i), 0, a_rdy, tbl[i].rdy);
         chk($sformatf("tbl%0d_out_valid", i), 0, a_ov, tbl[i].ov);
         chk($sformatf("tbl%0d_acc", i), 0, a_acc, tbl[i].acc);
         chk($sformatf("tbl%0d_cnt", i), 0, a_cnt, tbl[i].cnt);
         chk($sformatf("tbl%0d_ovf", i), 0, a_ovf, tbl[i].ovf);
         step();
      end

      // asynchronous reset while holding a finished batch
      for (int i = 0; i < 4; i++) begin
         set_in(0, 1, 127, 0);
         step();
      end
      set_in(0, 0, 0, 0);
      step();
      chk("hold_out_valid", 0, a_ov, 1);
      chk("hold_acc", 0, a_acc, 508);
      rst_n = 1'b0;
      #1;
      chk("async_out_valid", 0, a_ov, 0);
      chk("async_acc", 0, a_acc, 0);
      chk("async_cnt", 0, a_cnt, 0);
      chk("async_ovf", 0, a_ovf, 0);
      rst_n = 1'b1;
      #1;
      chk("release_in_ready", 0, a_rdy, 1);
      step();
      chk("release_acc", 0, a_acc, 0);

      // overflow on the 8-bit, 3-sample instance
      do_reset();
      for (int i = 0; i < 3; i++) begin
         set_in(0, 1, 127, 0);
         step();
      end
      set_in(0, 0, 0, 0);
      step();
      chk("ovf_out_valid", 1, b_ov, 1);
`ifdef SUM_ACCUMULATOR_SATURATE_EN
      chk("ovf_acc", 1, b_acc, 255);
`else
      chk("ovf_acc", 1, b_acc, 125);
`endif
      chk("ovf_flag", 1, b_ovf, 1);
      chk("ovf_cnt", 1, b_cnt, 3);
      set_in(0, 0, 0, 1);
      step();
      chk("ovf_clear_flag", 1, b_ovf, 0);
      chk("ovf_clear_acc", 1, b_acc, 0);

      // single-sample batches alternate ACCUM and HOLD
      do_reset();
      set_in(0, 1, 100, 0);
      #3;
      chk("n1_in_ready0", 2, c_rdy, 1);
      step();
      set_in(0, 1, 5, 1);
      #3;
      chk("n1_out_valid", 2, c_ov, 1);
      chk("n1_acc", 2, c_acc, 100);
      chk("n1_cnt", 2, c_cnt, 1);
      chk("n1_in_ready_hold", 2, c_rdy, 0);
      step();
      set_in(0, 1, 5, 0);
      #3;
      chk("n1_in_ready1", 2, c_rdy, 1);
      chk("n1_out_valid_low", 2, c_ov, 0);
      step();
      chk("n1_out_valid2", 2, c_ov, 1);
      chk("n1_acc2", 2, c_acc, 5);

      // randomized run against the reference model
      do_reset();
      for (int k = 0; k < 3; k++) begin
         m_sum[k] = 0; m_cnt[k] = 0; m_hold[k] = 0;
      end
      for (int n = 0; n < 600; n++) begin
         bit rc, riv, rordy;
         int rv;
         rc    = ($urandom_range(0, 19) == 0);
         riv   = ($urandom_range(0, 3) != 0);
         rordy = ($urandom_range(0, 2) == 0);
         rv    = ($urandom_range(0, 3) == 0) ? 127 : int'($urandom_range(0, 127));
         set_in(rc, riv, rv, rordy);
         #3;
         for (int k = 0; k < 3; k++) model_check(k, rc);
         for (int k = 0; k < 3; k++) model_step(k, rc, riv, rv, rordy);
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
